// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a single
// line-refill memory port. One access is in flight at a time. The access
// ends either with a one-cycle done pulse and the captured line on
// line_out, or, if memory stays silent for TIMEOUT cycles, with a
// one-cycle err pulse.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [31:0]  addr0,
    input  logic [31:0]  addr1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic         err0,
    output logic         err1,
    output logic [127:0] line_out,
    output logic [31:0]  mem_addr,
    output logic         mem_req,
    input  logic [127:0] mem_data_in,
    input  logic         mem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Count value seen in the last permitted BUSY cycle; the increment
    // taken at the end of that cycle is what reaches TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t        state;
    state_t        state_next;

    logic          winner;      // 0: requester 0 owns the port, 1: requester 1
    logic          last_gnt;    // requester served by the most recent access
    logic [7:0]    wait_cnt;
    logic [31:0]   addr_lat;
    logic [127:0]  line_q;
    logic          err0_q;
    logic          err1_q;

    logic          pick_valid;
    logic          pick;
    logic [31:0]   pick_addr;
    logic          accept;
    logic          capture;
    logic          timeout_hit;

    // Byte offset within the line is irrelevant for whole-line refills.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^{addr0[3:0], addr1[3:0]};

    // Round-robin choice: a lone requester always wins, a tie goes to the
    // requester that was not served last.
    always_comb begin
        pick_valid = req0 | req1;
        pick       = 1'b0;
        if (req0 && req1) begin
            pick = ~last_gnt;
        end else if (req1) begin
            pick = 1'b1;
        end
        pick_addr = pick ? {addr1[31:4], 4'b0000} : {addr0[31:4], 4'b0000};
    end

    // Next-state logic and the per-cycle events derived from it.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // Data arriving on the last permitted cycle still wins over
                // the timeout.
                if (mem_ready) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winner and its line-aligned address when an access starts;
    // later address or request changes cannot disturb the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner   <= 1'b0;
            addr_lat <= 32'd0;
        end else if (accept) begin
            winner   <= pick;
            addr_lat <= pick_addr;
        end
    end

    // Wait counter: cleared when BUSY is entered, counts silent BUSY cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (accept) begin
            wait_cnt <= 8'd0;
        end else if (state == BUSY && !mem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Line capture; memory data is only looked at while BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= 128'd0;
        end else if (capture) begin
            line_q <= mem_data_in;
        end
    end

    // Last-grant history advances when an access finishes, either way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (state == DONE || timeout_hit) begin
            last_gnt <= winner;
        end
    end

    // Timeout pulse, visible during the first IDLE cycle after the abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            err0_q <= timeout_hit & ~winner;
            err1_q <= timeout_hit & winner;
        end
    end

    assign mem_req  = (state == BUSY);
    assign mem_addr = addr_lat;
    assign line_out = line_q;
    assign gnt0     = (state == BUSY || state == DONE) && !winner;
    assign gnt1     = (state == BUSY || state == DONE) && winner;
    assign done0    = (state == DONE) && !winner;
    assign done1    = (state == DONE) && winner;
    assign err0     = err0_q;
    assign err1     = err1_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles a memory access waits in BUSY before it is aborted (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports req0 and req1, input, 1 bit each: line-refill request from requester 0 (I-cache) and requester 1 (prefetch/debug).
REQ-005 SHALL have ports addr0 and addr1, input, 32 bits each: byte address of the requested line.
REQ-006 SHALL have ports gnt0 and gnt1, output, 1 bit each: requester owns the memory port.
REQ-007 SHALL have ports done0 and done1, output, 1 bit each: one-cycle pulse meaning line data is valid.
REQ-008 SHALL have ports err0 and err1, output, 1 bit each: one-cycle pulse meaning the access timed out.
REQ-009 SHALL have port line_out, output, 128 bits: the returned line, shared by both requesters.
REQ-010 SHALL have port mem_addr, output, 32 bits: line-aligned memory address.
REQ-011 SHALL have port mem_req, output, 1 bit: memory request.
REQ-012 SHALL have port mem_data_in, input, 128 bits: memory line data.
REQ-013 SHALL have port mem_ready, input, 1 bit: memory data valid.

Function
REQ-014 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-015 In IDLE, with any req asserted, SHALL pick a winner, latch {addr[31:4],4'b0}, and go to BUSY on the next edge.
REQ-016 SHALL arbitrate round-robin: on simultaneous req0 and req1, the requester not granted last wins; after reset, requester 0 wins the first tie.
REQ-017 A single requester SHALL win regardless of last-grant history.
REQ-018 mem_req SHALL be 1 exactly while the state is BUSY; mem_addr SHALL hold the latched address throughout BUSY.
REQ-019 In BUSY, mem_ready=1 SHALL capture mem_data_in into line_out and go to DONE; mem_data_in SHALL be ignored at all other times.
REQ-020 In DONE, done of the winner SHALL be 1 for exactly one cycle; next state IDLE; the last-grant register SHALL update to the winner.
REQ-021 gnt of the winner SHALL be 1 from the BUSY entry edge through the DONE cycle; gnt0 and gnt1 SHALL never both be 1.
REQ-022 Minimum latency: req sampled at edge N, mem_ready high in the first BUSY cycle -> done high in cycle N+2.
REQ-023 line_out SHALL hold its value until the next capture.
REQ-024 An 8-bit wait counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ready.
REQ-025 When the wait counter reaches TIMEOUT in BUSY with mem_ready=0, SHALL go to IDLE, pulse err of the winner for one cycle (the first IDLE cycle), and update last-grant.
REQ-026 mem_ready=1 on the same cycle the timeout is reached SHALL complete normally; no err pulse.
REQ-027 Deasserting req during BUSY SHALL NOT abort the access; done still pulses; the next arbitration is unaffected.
REQ-028 A req held high after done SHALL be treated as a new request (re-arbitrated in IDLE).
REQ-029 A new request SHALL be accepted no earlier than the IDLE cycle after DONE, so back-to-back accesses are spaced by at least one idle cycle.
REQ-030 addr changes while the requester is granted SHALL NOT affect mem_addr.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, gnt0/1=0, done0/1=0, err0/1=0, mem_req=0, mem_addr=0, line_out=0, wait counter=0, and last-grant=1.
REQ-032 Reset asserted during BUSY SHALL drop mem_req asynchronously and discard the access; no done or err pulse follows.
REQ-033 After rst deasserts, the first arbitration SHALL occur on the first rising edge with rst=0.

Verification
REQ-034 Single request: req0=1, addr0=0x0000_1234; mem_ready on the 3rd BUSY cycle with data 0xA5..A5 -> mem_addr=0x0000_1230, mem_req high 3 cycles, done0 one pulse, line_out=0xA5..A5, gnt1 never high.
REQ-035 Tie then rotate: req0=req1=1 held continuously after reset -> grants alternate 0,1,0,1 over 4 accesses; never both gnt.
REQ-036 Timeout: TIMEOUT=4, req1=1, mem_ready never asserted -> mem_req high 4 cycles, err1 one pulse, done1 never, then req0 wins if both pending.
REQ-037 Boundary: mem_ready asserted exactly on the timeout cycle -> done pulses, err stays 0, line_out updated.
REQ-038 Reset mid-access: rst pulsed in 2nd BUSY cycle -> mem_req=0 in the same cycle, all outputs 0, no done; next req0 is served starting with mem_addr from the new addr0.
REQ-039 Request withdrawn: req0 drops in BUSY, addr0 changed -> mem_addr unchanged, done0 still pulses, no new access until a req reasserts.
